memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 34 +++
 rtl/memory_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundle of instruction master, data master and memory port signals
// slave modport: arbiter view (takes requests, drives memory); master modport: environment view
interface memory_arbiter_if;
  logic        i_req;
  logic [31:0] i_address;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_option;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_option;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_response;
  logic [31:0] mem_read_data;
  modport slave (
    input  i_req, i_address, d_req, d_we, d_option, d_address, d_wdata, mem_response, mem_read_data,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output mem_read, mem_write, mem_option, mem_address, mem_write_data
  );
  modport master (
    output i_req, i_address, d_req, d_we, d_option, d_address, d_wdata, mem_response, mem_read_data,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  mem_read, mem_write, mem_option, mem_address, mem_write_data
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates an instruction and a data master onto one memory port with timeout
// Ports: clk   - system clock, rising edge
//        reset - asynchronous active-low reset
//        bus   - slave modport: i_* instruction master, d_* data master, mem_* memory port
// All outputs are registered; ties go to the master not served most recently.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state, state_d;
  logic i_last, sel_d, gnt_i, gnt_d, misaligned, done;
  logic [7:0] cnt;
  // i_last set means the instruction master was served last, so a tie goes to data
  always_comb begin
    gnt_i = bus.i_req && (!bus.d_req || !i_last);
    gnt_d = bus.d_req && !gnt_i;
    misaligned = (bus.d_option[1:0] == 2'b01 && bus.d_address[0]) ||
                 (bus.d_option[1:0] == 2'b10 && bus.d_address[1:0] != 2'b00);
    done = bus.mem_response || cnt == 8'(TIMEOUT_CYCLES);
    state_d = state == IDLE ? (gnt_d && misaligned ? RELEASE : (gnt_i || gnt_d) ? BUSY : IDLE) :
              state == BUSY ? (done ? RELEASE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_option     <= 3'b000;
      bus.mem_address    <= 32'h0;
      bus.mem_write_data <= 32'h0;
      bus.i_ack          <= 1'b0;
      bus.i_err          <= 1'b0;
      bus.i_rdata        <= 32'h0;
      bus.d_ack          <= 1'b0;
      bus.d_err          <= 1'b0;
      bus.d_rdata        <= 32'h0;
      cnt                <= 8'd0;
      i_last             <= 1'b0;
      sel_d              <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.i_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      if (state == IDLE && gnt_i) begin
        bus.mem_read    <= 1'b1;
        bus.mem_write   <= 1'b0;
        bus.mem_option  <= 3'b010;
        bus.mem_address <= bus.i_address;
        sel_d           <= 1'b0;
        cnt             <= 8'd1;
      end else if (state == IDLE && gnt_d && misaligned) begin
        bus.d_ack <= 1'b1;
        bus.d_err <= 1'b1;
        i_last    <= 1'b0;
      end else if (state == IDLE && gnt_d) begin
        bus.mem_read       <= !bus.d_we;
        bus.mem_write      <= bus.d_we;
        bus.mem_option     <= bus.d_option;
        bus.mem_address    <= bus.d_address;
        bus.mem_write_data <= bus.d_wdata;
        sel_d              <= 1'b1;
        cnt                <= 8'd1;
      end else if (state == BUSY && done) begin
        bus.mem_read  <= 1'b0;
        bus.mem_write <= 1'b0;
        bus.i_ack     <= !sel_d;
        bus.d_ack     <= sel_d;
        bus.i_err     <= !sel_d && !bus.mem_response;
        bus.d_err     <= sel_d && !bus.mem_response;
        i_last        <= !sel_d;
        if (bus.mem_response && !sel_d) bus.i_rdata <= bus.mem_read_data;
        if (bus.mem_response && sel_d && !bus.mem_write) bus.d_rdata <= bus.mem_read_data;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule
